stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Mode controller sitting downstream of the tick generator. Consumes the 1 Hz, 2 Hz, fast-scan and blink
//   ticks plus raw buttons/switches; sequences RUN/PAUSE/ADJUST modes; owns the minutes/seconds counters
//   and per-field blanking that feed the 7-seg display driver.
// PARAMETERS
//   DB_SAMPLES  3   consecutive tick_fast samples of a new level before a button state is accepted (>=1)
//   MAX_MIN     59  highest minutes value; minutes wrap MAX_MIN->0 (must be <=63)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  reset, synchronous, active-low (0 = reset)
//   tick_1hz   in   1  1-cycle pulse, run-mode count tick
//   tick_2hz   in   1  1-cycle pulse, adjust-mode step tick
//   tick_fast  in   1  1-cycle pulse, debounce sample strobe
//   tick_blink in   1  1-cycle pulse, blink phase toggle
//   btn_pause  in   1  raw pause button, async, active-high
//   btn_reset  in   1  raw count-clear button, async, active-high
//   sw_adj     in   1  raw adjust switch, async level (1 = adjust)
//   sw_sel     in   1  raw field select, async level (0 = minutes, 1 = seconds)
//   minutes    out  6  binary 0..MAX_MIN
//   seconds    out  6  binary 0..59
//   blank_min  out  1  1 = display driver blanks minute digits
//   blank_sec  out  1  1 = display driver blanks second digits
//   paused     out  1  state == PAUSE
//   adj_active out  1  state == ADJUST
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=RUN, ret_state=RUN, minutes=seconds=0, blink_phase=0, all outputs 0,
//     synchronisers/debounce counters/stable levels 0. Reset mid-ADJUST or mid-debounce fully aborts.
//   Input conditioning: all 4 raw inputs pass a 2-FF synchroniser. Buttons: on each tick_fast, if synced
//     level != stable level, increment counter, else clear it; when counter reaches DB_SAMPLES, stable<=level
//     and counter<=0. Press = 1-cycle pulse on stable 0->1. Switches use synced level directly.
//   FSM (registered, all outputs registered, update visible the cycle after the causing event):
//     RUN    : tick_1hz advances count. pause press -> PAUSE. sw_adj==1 -> ADJUST, ret_state<=RUN.
//     PAUSE  : no advance. pause press -> RUN. sw_adj==1 -> ADJUST, ret_state<=PAUSE.
//     ADJUST : tick_2hz increments selected field only. tick_1hz and pause press ignored.
//              sw_adj==0 -> ret_state.
//     Ticks in the cycle of a transition are evaluated under the current (pre-transition) state.
//   Counting: seconds 59->0 with carry +1 to minutes; minutes MAX_MIN->0, no further carry.
//     ADJUST step wraps the selected field (59->0 or MAX_MIN->0) with NO carry into the other field.
//   btn_reset press: minutes=seconds=0 next cycle in any state; state/ret_state unchanged; wins over any
//     tick in the same cycle.
//   Blink: blink_phase toggles on every tick_blink regardless of state.
//     ADJUST: blank_min = ~sel & blink_phase, blank_sec = sel & blink_phase. Otherwise both 0.
//   Widths: compare/increment in 6 bits; no value outside 0..59 / 0..MAX_MIN is ever presented.
// TESTING (bench drives ticks directly, DB_SAMPLES=3)
//   1. Release reset, 60 tick_1hz -> seconds=0, minutes=1; preload 59:59, 1 tick_1hz -> 00:00.
//   2. btn_pause held for 3 tick_fast -> paused=1 one cycle after the accept; 5 tick_1hz -> count unchanged;
//      second press -> paused=0, counting resumes.
//   3. btn_pause high for only 2 tick_fast then low -> no press, state RUN, paused=0.
//   4. seconds=58, sw_adj=1, sw_sel=1, 3 tick_2hz -> seconds=1, minutes unchanged; tick_1hz ignored;
//      blank_sec follows blink_phase, blank_min=0.
//   5. Enter ADJUST from PAUSE, then sw_adj=0 -> paused=1, adj_active=0; enter from RUN -> resumes RUN.
//   6. btn_reset press coincident with tick_1hz at 12:34 -> 00:00; rst=0 mid-ADJUST -> all outputs 0, RUN.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Purpose : RUN/PAUSE/ADJUST mode controller owning the mm:ss counters and per-field blanking.
// Latency : raw inputs pass a 2-FF synchroniser, then button debounce; every output is registered and
//           changes the cycle after its cause.
// Backpressure: none. Tick inputs are single-cycle strobes and are consumed in the cycle they arrive.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-low reset (0 = reset)
//   i_tick_1hz / i_tick_2hz run-mode count tick / adjust-mode step tick
//   i_tick_fast             debounce sample strobe
//   i_tick_blink            blink phase toggle
//   i_btn_pause/i_btn_reset raw async buttons, active-high
//   i_sw_adj / i_sw_sel     raw async switches (adjust enable / field select, 1 = seconds)
//   o_minutes / o_seconds   binary count, 0..MAX_MIN / 0..59
//   o_blank_min/o_blank_sec per-field display blanking
//   o_paused / o_adj_active mode flags
module stopwatch_ctrl #(
  parameter int DB_SAMPLES = 3,
  parameter int MAX_MIN    = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_tick_2hz,
  input  logic       i_tick_fast,
  input  logic       i_tick_blink,
  input  logic       i_btn_pause,
  input  logic       i_btn_reset,
  input  logic       i_sw_adj,
  input  logic       i_sw_sel,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_blank_min,
  output logic       o_blank_sec,
  output logic       o_paused,
  output logic       o_adj_active
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  // The counter only needs to reach DB_SAMPLES-1; the accepting sample clears it.
  localparam int         CW       = (DB_SAMPLES < 2) ? 1 : $clog2(DB_SAMPLES);
  localparam logic [5:0] MIN_MAX  = 6'(MAX_MIN);
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_SAMPLES - 1);

  // Bit order of the synchroniser bus: {sel, adj, btn_reset, btn_pause}.
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [1:0]    r_stable;
  logic [1:0]    r_stable_d;
  logic [CW-1:0] r_db_cnt [0:1];

  state_t        r_state;
  state_t        r_ret;
  logic [5:0]    r_minutes;
  logic [5:0]    r_seconds;
  logic          r_blink;
  logic          r_blank_min;
  logic          r_blank_sec;
  logic          r_paused;
  logic          r_adj_active;

  logic [1:0]    w_press;
  logic          w_adj;
  logic          w_sel;
  state_t        w_state_nxt;
  state_t        w_ret_nxt;
  logic [5:0]    w_min_nxt;
  logic [5:0]    w_sec_nxt;
  logic          w_blink_nxt;

  // Using >= rather than == guarantees the field can never leave its legal range.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  assign w_press = r_stable & ~r_stable_d;
  assign w_adj   = r_sync2[2];
  assign w_sel   = r_sync2[3];

  // Synchroniser and button debounce.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= {i_sw_sel, i_sw_adj, i_btn_reset, i_btn_pause};
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      if (i_tick_fast) begin
        for (int i = 0; i < 2; i++) begin
          if (r_sync2[i] != r_stable[i]) begin
            if (r_db_cnt[i] == DB_LAST) begin
              r_stable[i] <= r_sync2[i];
              r_db_cnt[i] <= '0;
            end else begin
              r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
            end
          end else begin
            r_db_cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Next-state, next-count and blink. Ticks are judged against the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_min_nxt   = r_minutes;
    w_sec_nxt   = r_seconds;
    w_blink_nxt = r_blink ^ i_tick_blink;

    if (w_press[1]) begin
      w_min_nxt = 6'd0;
      w_sec_nxt = 6'd0;
    end else if (r_state == ST_RUN && i_tick_1hz) begin
      if (r_seconds >= SEC_MAX) begin
        w_sec_nxt = 6'd0;
        w_min_nxt = wrap_inc(r_minutes, MIN_MAX);
      end else begin
        w_sec_nxt = r_seconds + 6'd1;
      end
    end else if (r_state == ST_ADJUST && i_tick_2hz) begin
      // Adjust steps wrap within the selected field only; no carry.
      if (w_sel) w_sec_nxt = wrap_inc(r_seconds, SEC_MAX);
      else       w_min_nxt = wrap_inc(r_minutes, MIN_MAX);
    end

    // A pause press that coincides with the adjust switch wins; the switch is seen next cycle.
    case (r_state)
      ST_RUN: begin
        if (w_press[0]) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_adj) begin
          w_state_nxt = ST_ADJUST;
          w_ret_nxt   = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (w_press[0]) begin
          w_state_nxt = ST_RUN;
        end else if (w_adj) begin
          w_state_nxt = ST_ADJUST;
          w_ret_nxt   = ST_PAUSE;
        end
      end
      ST_ADJUST: begin
        if (!w_adj) w_state_nxt = r_ret;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_ret_nxt   = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_RUN;
      r_ret        <= ST_RUN;
      r_minutes    <= 6'd0;
      r_seconds    <= 6'd0;
      r_blink      <= 1'b0;
      r_blank_min  <= 1'b0;
      r_blank_sec  <= 1'b0;
      r_paused     <= 1'b0;
      r_adj_active <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_minutes    <= w_min_nxt;
      r_seconds    <= w_sec_nxt;
      r_blink      <= w_blink_nxt;
      r_blank_min  <= (w_state_nxt == ST_ADJUST) & ~w_sel & w_blink_nxt;
      r_blank_sec  <= (w_state_nxt == ST_ADJUST) &  w_sel & w_blink_nxt;
      r_paused     <= (w_state_nxt == ST_PAUSE);
      r_adj_active <= (w_state_nxt == ST_ADJUST);
    end
  end

  assign o_minutes    = r_minutes;
  assign o_seconds    = r_seconds;
  assign o_blank_min  = r_blank_min;
  assign o_blank_sec  = r_blank_sec;
  assign o_paused     = r_paused;
  assign o_adj_active = r_adj_active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose : self-checking bench for stopwatch_ctrl against a behavioural model.
// Latency : model tracks the DUT cycle by cycle; outputs compared every negedge.
// Backpressure: n/a.
module tb_stopwatch_ctrl;

  localparam int DB      = 3;
  localparam int MAX_MIN = 59;
  localparam int M_RUN   = 0;
  localparam int M_PAUSE = 1;
  localparam int M_ADJ   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_fast = 1'b0, tick_blink = 1'b0;
  logic       btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic [5:0] minutes, seconds;
  logic       blank_min, blank_sec, paused, adj_active;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ctrl #(.DB_SAMPLES(DB), .MAX_MIN(MAX_MIN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick_1hz  (tick_1hz),
    .i_tick_2hz  (tick_2hz),
    .i_tick_fast (tick_fast),
    .i_tick_blink(tick_blink),
    .i_btn_pause (btn_pause),
    .i_btn_reset (btn_reset),
    .i_sw_adj    (sw_adj),
    .i_sw_sel    (sw_sel),
    .o_minutes   (minutes),
    .o_seconds   (seconds),
    .o_blank_min (blank_min),
    .o_blank_sec (blank_sec),
    .o_paused    (paused),
    .o_adj_active(adj_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: mode as an integer, time as total seconds modulo an hour of MAX_MIN+1 minutes.
  int         m_mode, m_ret, m_min, m_sec, m_tot, m_old;
  int         m_cnt [2];
  logic [3:0] m_s1, m_s2;
  logic [1:0] m_stab, m_stab_d;
  logic       m_blink, e_bmin, e_bsec, pp, rp, adj, sel;

  always @(posedge clk) begin
    if (!rst) begin
      m_mode = M_RUN; m_ret = M_RUN; m_min = 0; m_sec = 0;
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_stab_d = '0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_blink = 1'b0; e_bmin = 1'b0; e_bsec = 1'b0;
    end else begin
      pp  = m_stab[0] & ~m_stab_d[0];
      rp  = m_stab[1] & ~m_stab_d[1];
      adj = m_s2[2];
      sel = m_s2[3];
      m_old = m_mode;
      if (rp) begin
        m_min = 0; m_sec = 0;
      end else if (m_old == M_RUN && tick_1hz) begin
        m_tot = (m_min * 60 + m_sec + 1) % ((MAX_MIN + 1) * 60);
        m_min = m_tot / 60;
        m_sec = m_tot % 60;
      end else if (m_old == M_ADJ && tick_2hz) begin
        if (sel) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % (MAX_MIN + 1);
      end
      if (m_old == M_RUN) begin
        if (pp) m_mode = M_PAUSE;
        else if (adj) begin m_mode = M_ADJ; m_ret = M_RUN; end
      end else if (m_old == M_PAUSE) begin
        if (pp) m_mode = M_RUN;
        else if (adj) begin m_mode = M_ADJ; m_ret = M_PAUSE; end
      end else begin
        if (!adj) m_mode = m_ret;
      end
      m_stab_d = m_stab;
      if (tick_fast) begin
        for (int i = 0; i < 2; i++) begin
          if (m_s2[i] != m_stab[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == DB) begin m_stab[i] = m_s2[i]; m_cnt[i] = 0; end
          end else begin
            m_cnt[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {sw_sel, sw_adj, btn_reset, btn_pause};
      if (tick_blink) m_blink = ~m_blink;
      e_bmin = (m_mode == M_ADJ) && !sel && m_blink;
      e_bsec = (m_mode == M_ADJ) &&  sel && m_blink;
    end
  end

  // One clock: compare against the model on the falling edge, then drop the tick strobes.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("minutes",    int'(minutes),    m_min);
    chk("seconds",    int'(seconds),    m_sec);
    chk("paused",     int'(paused),     int'(m_mode == M_PAUSE));
    chk("adj_active", int'(adj_active), int'(m_mode == M_ADJ));
    chk("blank_min",  int'(blank_min),  int'(e_bmin));
    chk("blank_sec",  int'(blank_sec),  int'(e_bsec));
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_fast = 1'b0; tick_blink = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic fast(input int n);
    repeat (n) begin tick_fast = 1'b1; cyc(); end
  endtask

  // Full debounced press and release of button 0 (pause) or 1 (reset).
  task automatic press_btn(input int b);
    if (b == 0) btn_pause = 1'b1; else btn_reset = 1'b1;
    idle(3); fast(DB); idle(1);
    if (b == 0) btn_pause = 1'b0; else btn_reset = 1'b0;
    idle(3); fast(DB);
  endtask

  // Enters ADJUST, clears the count, then steps minutes and seconds; leaves ADJUST active, sel=1.
  task automatic set_time(input int mm, input int ss);
    sw_adj = 1'b1; idle(4);
    press_btn(1);
    sw_sel = 1'b0; idle(3);
    repeat (mm) begin tick_2hz = 1'b1; cyc(); end
    sw_sel = 1'b1; idle(3);
    repeat (ss) begin tick_2hz = 1'b1; cyc(); end
  endtask

  initial begin
    idle(2);
    chk("rst_min", int'(minutes), 0);
    chk("rst_sec", int'(seconds), 0);
    chk("rst_paused", int'(paused), 0);
    chk("rst_adj", int'(adj_active), 0);
    rst = 1'b1;

    // 1: minute carry, then full wrap from 59:59.
    repeat (60) begin tick_1hz = 1'b1; cyc(); end
    chk("t1_sec", int'(seconds), 0);
    chk("t1_min", int'(minutes), 1);
    set_time(59, 59);
    sw_adj = 1'b0; idle(4);
    chk("t1_pre_min", int'(minutes), 59);
    chk("t1_pre_sec", int'(seconds), 59);
    tick_1hz = 1'b1; cyc();
    chk("t1_wrap_min", int'(minutes), 0);
    chk("t1_wrap_sec", int'(seconds), 0);

    // 2: pause press after DB samples; paused one cycle after accept.
    btn_pause = 1'b1; idle(3); fast(DB);
    chk("t2_accept_paused", int'(paused), 0);
    idle(1);
    chk("t2_paused", int'(paused), 1);
    btn_pause = 1'b0; idle(3); fast(DB);
    repeat (5) begin tick_1hz = 1'b1; cyc(); end
    chk("t2_hold_sec", int'(seconds), 0);
    press_btn(0);
    chk("t2_resume_paused", int'(paused), 0);
    tick_1hz = 1'b1; cyc();
    chk("t2_resume_sec", int'(seconds), 1);

    // 3: too-short press is rejected.
    btn_pause = 1'b1; idle(3); fast(DB - 1);
    btn_pause = 1'b0; idle(3); fast(DB); idle(2);
    chk("t3_paused", int'(paused), 0);

    // 4: seconds adjust wraps without carry; 1 Hz ignored; blanking follows blink.
    set_time(0, 58);
    repeat (3) begin tick_2hz = 1'b1; cyc(); end
    chk("t4_sec", int'(seconds), 1);
    chk("t4_min", int'(minutes), 0);
    tick_1hz = 1'b1; cyc();
    chk("t4_ign_sec", int'(seconds), 1);
    tick_blink = 1'b1; cyc();
    chk("t4_bsec_a", int'(blank_sec), int'(m_blink));
    chk("t4_bmin_a", int'(blank_min), 0);
    tick_blink = 1'b1; cyc();
    chk("t4_bsec_b", int'(blank_sec), int'(m_blink));
    chk("t4_adj", int'(adj_active), 1);
    sw_adj = 1'b0; idle(4);

    // 5: ADJUST returns to the mode it was entered from.
    press_btn(0);
    chk("t5_paused", int'(paused), 1);
    sw_adj = 1'b1; idle(4);
    chk("t5_in_adj", int'(adj_active), 1);
    chk("t5_in_adj_paused", int'(paused), 0);
    sw_adj = 1'b0; idle(4);
    chk("t5_ret_paused", int'(paused), 1);
    chk("t5_ret_adj", int'(adj_active), 0);
    press_btn(0);
    sw_adj = 1'b1; idle(4); sw_adj = 1'b0; idle(4);
    chk("t5_run_paused", int'(paused), 0);
    tick_1hz = 1'b1; cyc();
    chk("t5_run_sec", int'(seconds), 2);

    // 6: clear wins over a coincident 1 Hz tick; reset aborts ADJUST.
    set_time(12, 34);
    sw_adj = 1'b0; idle(4);
    chk("t6_pre_min", int'(minutes), 12);
    chk("t6_pre_sec", int'(seconds), 34);
    btn_reset = 1'b1; idle(3); fast(DB);
    tick_1hz = 1'b1; cyc();
    chk("t6_clr_min", int'(minutes), 0);
    chk("t6_clr_sec", int'(seconds), 0);
    btn_reset = 1'b0; idle(3); fast(DB);
    sw_adj = 1'b1; idle(4);
    chk("t6_adj", int'(adj_active), 1);
    rst = 1'b0; tick_blink = 1'b1; cyc();
    chk("t6_rst_adj", int'(adj_active), 0);
    chk("t6_rst_paused", int'(paused), 0);
    chk("t6_rst_bmin", int'(blank_min), 0);
    chk("t6_rst_bsec", int'(blank_sec), 0);
    rst = 1'b1; sw_adj = 1'b0; idle(4);
    chk("t6_after_adj", int'(adj_active), 0);

    // Randomised soak against the model.
    for (int n = 0; n < 3000; n++) begin
      tick_1hz   = ($urandom_range(0, 4) == 0);
      tick_2hz   = ($urandom_range(0, 3) == 0);
      tick_fast  = ($urandom_range(0, 2) == 0);
      tick_blink = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 79) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, 59) == 0) sw_adj = ~sw_adj;
      if ($urandom_range(0, 19) == 0) sw_sel = ~sw_sel;
      rst = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
